// File: rtl/alu_iq_pkg.sv
// Shared types and decode helpers for the ALU issue queue.
package alu_iq_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_R32   = 7'b0111011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_I32   = 7'b0011011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
  } iq_entry_t;

  typedef struct packed {
    logic uses_rs1;
    logic uses_rs2;
    logic writes_rd;
  } src_info_t;

  // Unknown opcodes are treated conservatively: both sources checked, no rd written.
  function automatic src_info_t decode_srcs(input logic [31:0] inst);
    src_info_t info;
    case (inst[6:0])
      OP_R, OP_R32:     info = '{uses_rs1: 1'b1, uses_rs2: 1'b1, writes_rd: 1'b1};
      OP_I, OP_I32:     info = '{uses_rs1: 1'b1, uses_rs2: 1'b0, writes_rd: 1'b1};
      OP_LUI, OP_AUIPC: info = '{uses_rs1: 1'b0, uses_rs2: 1'b0, writes_rd: 1'b1};
      default:          info = '{uses_rs1: 1'b1, uses_rs2: 1'b1, writes_rd: 1'b0};
    endcase
    return info;
  endfunction

endpackage

// File: rtl/iq_scoreboard.sv
// Pending-destination scoreboard for the ALU issue queue.
// WB_BYPASS_EN: hazard check sees the current-cycle writeback as already cleared.
module iq_scoreboard (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        set_en,
  input  logic [4:0]  set_idx,
  input  logic        clr_en,
  input  logic [4:0]  clr_idx,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic        uses_rs1,
  input  logic        uses_rs2,
  output logic        hazard,
  output logic [31:0] busy_vec
);

  logic [31:0] busy_nxt;
  logic [31:0] busy_chk;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    busy_nxt = busy_vec;
    if (clr_en) busy_nxt[clr_idx] = 1'b0;
    // Set applied after clear: a newer producer of the same register stays pending.
    if (set_en) busy_nxt[set_idx] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      busy_vec <= '0;
    else if (flush) busy_vec <= '0;
    else            busy_vec <= busy_nxt;
  end

  always_comb begin
    busy_chk = busy_vec;
`ifdef WB_BYPASS_EN
    if (clr_en) busy_chk[clr_idx] = 1'b0;
`endif
  end

  assign hazard = (uses_rs1 && busy_chk[rs1]) || (uses_rs2 && busy_chk[rs2]);

endmodule

// File: rtl/alu_issue_queue.sv
// In-order single-issue buffer in front of the ALU pipeline with RAW-hazard gating.
// Optional WB_BYPASS_EN lets a dependent issue in its producer's writeback cycle.
module alu_issue_queue
  import alu_iq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [63:0]      in_pc,
  output logic             iss_valid,
  input  logic             iss_ready,
  output logic [31:0]      iss_inst,
  output logic [63:0]      iss_pc,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd_indx,
  output logic [CNT_W-1:0] count,
  output logic [31:0]      busy_vec
);

  localparam int PTR_W = $clog2(DEPTH);

  iq_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  iq_entry_t        head;
  src_info_t        head_src;
  logic             hazard;
  logic             slot_free;
  logic             enq;
  logic             deq;

  assign in_ready  = (count < CNT_W'(DEPTH));
  assign enq       = in_valid && in_ready;
  assign head      = mem[rd_ptr];
  assign head_src  = decode_srcs(head.inst);
  assign slot_free = !iss_valid || iss_ready;
  assign deq       = (count != '0) && !hazard && slot_free;

  // NOTE: FIFO storage is not reset; pointers and count define which entries are meaningful.
  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= '{inst: in_inst, pc: in_pc};
  end

  // DEPTH is a power of two, so pointer increments wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Issue slot: payload only reloads on dequeue, so it holds while stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iss_valid <= 1'b0;
      iss_inst  <= '0;
      iss_pc    <= '0;
    end else if (flush) begin
      iss_valid <= 1'b0;
      iss_inst  <= '0;
      iss_pc    <= '0;
    end else if (deq) begin
      iss_valid <= 1'b1;
      iss_inst  <= head.inst;
      iss_pc    <= head.pc;
    end else if (iss_ready) begin
      iss_valid <= 1'b0;
    end
  end

  iq_scoreboard u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .set_en   (deq && head_src.writes_rd),
    .set_idx  (head.inst[11:7]),
    .clr_en   (wb_valid),
    .clr_idx  (wb_rd_indx),
    .rs1      (head.inst[19:15]),
    .rs2      (head.inst[24:20]),
    .uses_rs1 (head_src.uses_rs1),
    .uses_rs2 (head_src.uses_rs2),
    .hazard   (hazard),
    .busy_vec (busy_vec)
  );

endmodule

// File: tb/tb_alu_issue_queue.sv
// Scoreboard bench for alu_issue_queue: directed vectors, issue-order monitor, status checks.
module tb_alu_issue_queue;
  import alu_iq_pkg::*;

  localparam int DEPTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_inst;
  logic [63:0]      in_pc;
  logic             iss_valid;
  logic             iss_ready;
  logic [31:0]      iss_inst;
  logic [63:0]      iss_pc;
  logic             wb_valid;
  logic [4:0]       wb_rd_indx;
  logic [CNT_W-1:0] count;
  logic [31:0]      busy_vec;

  int        n_cmp = 0;
  int        n_bad = 0;
  int        n_acc;
  iq_entry_t exp_q [$];
  iq_entry_t mon_e;

  alu_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_inst    (in_inst),
    .in_pc      (in_pc),
    .iss_valid  (iss_valid),
    .iss_ready  (iss_ready),
    .iss_inst   (iss_inst),
    .iss_pc     (iss_pc),
    .wb_valid   (wb_valid),
    .wb_rd_indx (wb_rd_indx),
    .count      (count),
    .busy_vec   (busy_vec)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Inputs are stable from posedge+1 to the next posedge, so the negedge sees the transfer.
  always @(negedge clk) begin
    if (!reset && iss_valid && iss_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL issue_unexpected: got inst 0x%08h, expected none", iss_inst);
      end else begin
        mon_e = exp_q.pop_front();
        check("issue_inst", {32'h0, iss_inst}, {32'h0, mon_e.inst});
        check("issue_pc", iss_pc, mon_e.pc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] inst, input logic [63:0] pc);
    iq_entry_t e;
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
    if (in_ready) begin
      e.inst = inst;
      e.pc   = pc;
      exp_q.push_back(e);
      n_acc++;
    end
  endtask

  task automatic wb(input logic [4:0] rd);
    wb_valid   = 1'b1;
    wb_rd_indx = rd;
    tick();
    wb_valid   = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || iss_valid) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
    end
  endtask

  function automatic logic [31:0] nop_inst(input int i);
    logic [11:0] imm;
    imm = 12'(i);
    return {imm, 5'd0, 3'b000, 5'd0, 7'b0010011};
  endfunction

  task automatic fill_six();
    iss_ready = 1'b0;
    offer(32'h0010_0213, 64'h3000);
    tick();
    for (int i = 1; i < 6; i++) begin
      offer(nop_inst(i), 64'h3000 + 64'(4 * i));
      tick();
    end
    in_valid = 1'b0;
    check("fill6_count", 64'(count), 64'd5);
    check("fill6_busy", 64'(busy_vec), 64'h10);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0;
    iss_ready = 1'b1; wb_valid = 1'b0; wb_rd_indx = '0; n_acc = 0;
    repeat (2) tick();
    reset = 1'b0;
    check("rst_count", 64'(count), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_iss_valid", 64'(iss_valid), 64'd0);
    check("rst_iss_inst", 64'(iss_inst), 64'd0);
    check("rst_iss_pc", iss_pc, 64'd0);
    check("rst_busy", 64'(busy_vec), 64'd0);

    // addi x1,x0,5: one edge to enqueue, one more to issue
    offer(32'h0050_0093, 64'h1000);
    tick();
    in_valid = 1'b0;
    check("lat_count", 64'(count), 64'd1);
    check("lat_not_yet", 64'(iss_valid), 64'd0);
    tick();
    check("lat_iss_valid", 64'(iss_valid), 64'd1);
    check("lat_iss_inst", 64'(iss_inst), 64'h0050_0093);
    check("lat_busy", 64'(busy_vec), 64'h2);

    // add x2,x1,x1 waits on x1; lui x3 queued behind it must not overtake
    offer(32'h0010_8133, 64'h1004);
    tick();
    in_valid = 1'b0;
    check("raw_held_valid", 64'(iss_valid), 64'd0);
    check("raw_held_count", 64'(count), 64'd1);
    tick();
    check("raw_still_held", 64'(iss_valid), 64'd0);
    offer(32'h0000_11B7, 64'h1008);
    tick();
    in_valid = 1'b0;
    check("inorder_count", 64'(count), 64'd2);
    check("inorder_valid", 64'(iss_valid), 64'd0);
    wb(5'd1);
`ifdef WB_BYPASS_EN
    check("bypass_issue", 64'(iss_valid), 64'd1);
    check("bypass_count", 64'(count), 64'd1);
`else
    check("wb_no_issue", 64'(iss_valid), 64'd0);
    check("wb_count", 64'(count), 64'd2);
`endif
    check("wb_clr_x1", 64'(busy_vec[1]), 64'd0);
    tick();
    check("busy_rd2_set", 64'(busy_vec[2]), 64'd1);
    tick();
    check("after_lui_busy", 64'(busy_vec), 64'hC);
    check("after_lui_count", 64'(count), 64'd0);

    // writebacks: rd=0 and a non-busy rd have no effect
    wb(5'd2);
    check("wb_rd2", 64'(busy_vec), 64'h8);
    wb(5'd0);
    check("wb_rd0_ignored", 64'(busy_vec), 64'h8);
    wb(5'd5);
    check("wb_not_busy", 64'(busy_vec), 64'h8);
    wb(5'd3);
    check("wb_rd3", 64'(busy_vec), 64'h0);

    // same-cycle set and clear of x1: set wins
    offer(32'h0070_0093, 64'h1100);
    tick();
    in_valid = 1'b0;
    wb(5'd1);
    check("set_wins_busy", 64'(busy_vec), 64'h2);
    check("set_wins_inst", 64'(iss_inst), 64'h0070_0093);
    wb(5'd1);
    check("set_wins_clear", 64'(busy_vec), 64'h0);
    wait_drain(20);

    // fill with the slot stalled: slot takes one, FIFO takes DEPTH, the rest bounce
    iss_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 10; i++) begin
      offer(nop_inst(i), 64'h2000 + 64'(4 * i));
      tick();
      if (i == 1) begin
        check("enq_deq_count", 64'(count), 64'd1);
        check("enq_deq_slot", 64'(iss_valid), 64'd1);
      end
    end
    check("full_accepted", 64'(n_acc), 64'd9);
    check("full_count", 64'(count), 64'd8);
    check("full_in_ready", 64'(in_ready), 64'd0);
    tick();
    tick();
    check("stall_inst", 64'(iss_inst), 64'(nop_inst(0)));
    check("stall_pc", iss_pc, 64'h2000);
    check("stall_valid", 64'(iss_valid), 64'd1);
    iss_ready = 1'b1;
    offer(nop_inst(77), 64'h2100);
    tick();
    in_valid = 1'b0;
    check("full_blocks_enq", 64'(count), 64'd7);
    wait_drain(40);
    check("drain_count", 64'(count), 64'd0);

    // flush mid-stream wins over a same-cycle enqueue and writeback
    fill_six();
    flush = 1'b1; in_valid = 1'b1; in_inst = nop_inst(99); wb_valid = 1'b1; wb_rd_indx = 5'd4;
    tick();
    flush = 1'b0; in_valid = 1'b0; wb_valid = 1'b0;
    exp_q.delete();
    check("flush_count", 64'(count), 64'd0);
    check("flush_iss_valid", 64'(iss_valid), 64'd0);
    check("flush_iss_inst", 64'(iss_inst), 64'd0);
    check("flush_iss_pc", iss_pc, 64'd0);
    check("flush_busy", 64'(busy_vec), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);

    // asynchronous reset mid-cycle
    fill_six();
    #2 reset = 1'b1;
    #1;
    exp_q.delete();
    check("areset_count", 64'(count), 64'd0);
    check("areset_iss_valid", 64'(iss_valid), 64'd0);
    check("areset_busy", 64'(busy_vec), 64'd0);
    tick();
    reset = 1'b0;

    iss_ready = 1'b1;
    offer(32'h0000_11B7, 64'h4000);
    tick();
    in_valid = 1'b0;
    wait_drain(20);
    check("post_reset_busy", 64'(busy_vec), 64'h8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
